// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to the i-cache, then raises start.
// Optional trailing XOR checksum byte with CHK/ERR states when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int          ADDR_W    = 19,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic [31:0]       o_instruction,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wea,
  output logic              o_start,
  output logic              o_busy,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_words
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t           state, state_nxt;
  logic [7:0]       cnt_lo;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hdr_count;
  logic [1:0]       lane;
  logic [23:0]      lanes;
  logic             xfer;
  logic             last_word;
  logic             restart;

  assign o_busy    = !rst && (state == HDR0 || state == HDR1 || state == DATA || state == CHK);
  assign s_ready   = o_busy;
  assign xfer      = s_valid && s_ready;
  assign hdr_count = CNT_W'({s_data, cnt_lo});
  // the word being completed has index o_words; its increment from the previous word has landed
  assign last_word = (o_words + CNT_W'(1)) == count;
  assign restart   = reload && (state == DONE || state == ERR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       ck_ok;

  assign ck_ok = (s_data == acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= (state == ERR) && !reload;
      if (restart)
        acc <= '0;
      else if (xfer && state != CHK)
        acc <= acc ^ s_data;
    end
  end
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0: if (xfer) state_nxt = HDR1;
      HDR1: if (xfer) state_nxt = (hdr_count != '0) ? DATA : END_ST;
      DATA: if (xfer && lane == 2'd3 && last_word) state_nxt = END_ST;
`ifdef LOADER_CHECKSUM_EN
      CHK:  if (xfer) state_nxt = ck_ok ? DONE : ERR;
      ERR:  if (reload) state_nxt = HDR0;
`endif
      DONE: if (reload) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lo        <= '0;
      count         <= '0;
      lane          <= '0;
      lanes         <= '0;
      o_instruction <= '0;
      o_addr        <= ADDR_W'(BASE_ADDR);
      o_wea         <= 1'b0;
      o_start       <= 1'b0;
      o_words       <= '0;
    end else begin
      o_wea   <= 1'b0;
      o_start <= (state == DONE) && !reload;
      // address/count advance in the cycle the write strobe is presented
      if (o_wea) begin
        o_addr  <= o_addr + ADDR_W'(1);
        o_words <= o_words + CNT_W'(1);
      end
      if (restart) begin
        o_addr  <= ADDR_W'(BASE_ADDR);
        o_words <= '0;
        lane    <= '0;
      end
      if (xfer) begin
        case (state)
          HDR0: cnt_lo <= s_data;
          HDR1: count  <= hdr_count;
          DATA: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: lanes[7:0]   <= s_data;
              2'd1: lanes[15:8]  <= s_data;
              2'd2: lanes[23:16] <= s_data;
              default: begin
                o_instruction <= {s_data, lanes};
                o_wea         <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader; two instances (base 0 and base 0x7FFFF) share the byte stream.
module tb_prog_loader;
  localparam logic [18:0] BASE_B = 19'h7FFFF;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, s_valid = 1'b0, reload = 1'b0;
  logic [7:0]  s_data = '0;
  logic        rdy_a, wea_a, start_a, busy_a, err_a;
  logic        rdy_b, wea_b, start_b, busy_b, err_b;
  logic [31:0] instr_a, instr_b;
  logic [18:0] addr_a, addr_b;
  logic [15:0] words_a, words_b;

  typedef struct packed { logic [18:0] addr; logic [31:0] data; } wr_t;
  wr_t         qa[$], qb[$];
  logic [31:0] words[$];
  int          checks = 0, errors = 0;

  prog_loader #(.ADDR_W(19), .BASE_ADDR(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_a), .reload(reload),
    .o_instruction(instr_a), .o_addr(addr_a), .o_wea(wea_a), .o_start(start_a), .o_busy(busy_a),
    .o_err(err_a), .o_words(words_a));

  prog_loader #(.ADDR_W(19), .BASE_ADDR(19'h7FFFF), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy_b), .reload(reload),
    .o_instruction(instr_b), .o_addr(addr_b), .o_wea(wea_b), .o_start(start_b), .o_busy(busy_b),
    .o_err(err_b), .o_words(words_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    wr_t w;
    if (wea_a === 1'b1) begin
      if (qa.size() == 0) chk("extra_wea_a", 1, 0);
      else begin
        w = qa.pop_front();
        chk("wr_addr_a", 32'(addr_a), 32'(w.addr));
        chk("wr_data_a", instr_a, w.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t w;
    if (wea_b === 1'b1) begin
      if (qb.size() == 0) chk("extra_wea_b", 1, 0);
      else begin
        w = qb.pop_front();
        chk("wr_addr_b", 32'(addr_b), 32'(w.addr));
        chk("wr_data_b", instr_b, w.data);
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!rdy_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("s_ready_wait", rdy_a, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Builds the byte stream from the word list, queues the expected writes, sends the first `limit` bytes.
  task automatic load(input int limit, input bit bad_ck, input int stall_at, input int stall_len,
                      input bit rnd_stall);
    logic [7:0] st[$];
    logic [7:0] ck;
    int         cnt, n;
    cnt = words.size();
    st.push_back(cnt[7:0]);
    st.push_back(cnt[15:8]);
    foreach (words[i]) for (int k = 0; k < 4; k++) st.push_back(words[i][8*k +: 8]);
    ck = '0;
    foreach (st[i]) ck ^= st[i];
    if (CK_EN) st.push_back(bad_ck ? ~ck : ck);
    n = (limit < 0 || limit > st.size()) ? st.size() : limit;
    foreach (words[i])
      if (2 + 4 * (i + 1) <= n) begin
        qa.push_back(wr_t'{addr: 19'(i), data: words[i]});
        qb.push_back(wr_t'{addr: BASE_B + 19'(i), data: words[i]});
      end
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) idle(stall_len);
      else if (rnd_stall && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_byte(st[i]);
    end
  endtask

  task automatic finish_check(input int cnt, input bit ok);
    repeat (2) @(posedge clk);
    #1;
    chk("start_a", start_a, ok);
    chk("start_b", start_b, ok);
    chk("err", err_a, !ok);
    chk("busy_end", busy_a, 0);
    chk("ready_end", rdy_a, 0);
    chk("words_a", 32'(words_a), cnt);
    chk("words_b", 32'(words_b), cnt);
    chk("drained_a", qa.size(), 0);
    chk("drained_b", qb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_held", start_a, ok);
    chk("err_held", err_a, !ok);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_start", start_a, 0);
    chk("reload_err", err_a, 0);
    chk("reload_ready", rdy_a, 1);
    chk("reload_busy", busy_b, 1);
    chk("reload_words", 32'(words_a), 0);
    chk("reload_addr_a", 32'(addr_a), 0);
    chk("reload_addr_b", 32'(addr_b), 32'(BASE_B));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, rdy_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_wea"}, wea_a, 0);
    chk({tag, "_start"}, start_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_addr_a"}, 32'(addr_a), 0);
    chk({tag, "_addr_b"}, 32'(addr_b), 32'(BASE_B));
    chk({tag, "_instr"}, instr_a, 0);
    chk({tag, "_words"}, 32'(words_a), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit bad;
    int cnt;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy_a, 1);

    words = '{32'h00100013, 32'h00A58533};
    load(-1, 1'b0, -1, 0, 1'b0);
    finish_check(2, 1'b1);

    // five idle cycles between bytes 2 and 3 of word 0
    load(-1, 1'b0, 4, 5, 1'b0);
    finish_check(2, 1'b1);

    words.delete();
    load(-1, 1'b0, -1, 0, 1'b0);
    finish_check(0, 1'b1);

    if (CK_EN) begin
      words = '{32'h00000013};
      load(-1, 1'b0, -1, 0, 1'b0);
      finish_check(1, 1'b1);
      load(-1, 1'b1, -1, 0, 1'b0);
      finish_check(1, 1'b0);
    end

    // reset in the middle of word 1 of a 3-word load
    words = '{$urandom, $urandom, $urandom};
    load(8, 1'b0, -1, 0, 1'b0);
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    chk("midrst_drained", qa.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    words = '{32'hDEADBEEF};
    load(-1, 1'b0, -1, 0, 1'b0);
    finish_check(1, 1'b1);

    for (int t = 0; t < 10; t++) begin
      cnt = $urandom_range(0, 6);
      words.delete();
      for (int i = 0; i < cnt; i++) words.push_back($urandom);
      bad = CK_EN && ($urandom_range(0, 2) == 0);
      load(-1, bad, -1, 0, 1'b1);
      finish_check(cnt, !bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Initiator side of the instruction-cache load port and the core `start` line.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive i-cache word addresses, then asserts a sticky start to release the pipeline's program counter.
- Sits between the off-chip/testbench byte source and the processor top-level.

Parameters:
- ADDR_W, 19, i-cache word-address width (matches the core's instruction write address).
- BASE_ADDR, 0, first word address written after each load.
- CNT_W, 16, width of the word-count header.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  byte source has data.
- s_data  input  8  byte payload.
- s_ready  output  1  loader can accept a byte.
- reload  input  1  one-cycle pulse; restarts the load from DONE or ERR.
- o_instruction  output  32  word to write into the i-cache.
- o_addr  output  ADDR_W  i-cache word address.
- o_wea  output  1  i-cache write enable, one cycle per word.
- o_start  output  1  core start; held high once the load completes.
- o_busy  output  1  load in progress (states HDR0..CHK).
- o_err  output  1  checksum failure (only meaningful with the optional feature).
- o_words  output  CNT_W  number of words written in the current load.

Behaviour:
- Reset values (async, rst=1): state=HDR0; s_ready=0 while rst is high; o_wea=0; o_start=0; o_err=0; o_addr=BASE_ADDR; o_instruction=0; o_words=0; byte lane=0; checksum accumulator=0.
- Byte transfer occurs when s_valid && s_ready on a rising edge. s_ready=1 in HDR0, HDR1, DATA and CHK; 0 in DONE and ERR.
- Stream format:
  - count[7:0], then count[15:8].
  - Then count×4 data bytes, least-significant byte first per word.
  - Then, with the feature enabled only, one checksum byte.
- States and transitions:
  - HDR0: accept a byte → latch count low byte → HDR1.
  - HDR1: accept a byte → latch count high byte.
    - count≠0 → DATA.
    - count=0 → CHK (feature on) or DONE (feature off).
  - DATA: each accepted byte fills lane 0..3.
    - On lane 3: the full word is registered onto o_instruction, and o_wea pulses high the NEXT cycle with the current o_addr.
    - o_addr then increments by 1 and o_words increments by 1 (o_addr wraps modulo 2^ADDR_W).
    - After the word whose index equals count-1 → CHK (feature on) or DONE (feature off).
  - CHK: accept one byte and compare it with the XOR of all header and data bytes.
    - Equal → DONE.
    - Unequal → ERR.
  - DONE: o_start=1 (registered; high the cycle after entering DONE) and held. reload → HDR0, o_start=0.
  - ERR: o_err=1 and held; o_start stays 0. reload → HDR0, o_err=0.
- reload in DONE/ERR also resets o_addr=BASE_ADDR, o_words=0 and the accumulator. reload in any other state is ignored.
- Back-to-back operation: a byte may be accepted in the same cycle o_wea is high. A new word every 4 cycles with s_valid held high.
- s_valid low stalls the FSM with no state change. Partial-word lanes are retained across stalls.
- Reset mid-load discards the partial word and count. Words already written remain in the i-cache, but o_start stays 0.
- o_busy = state ∈ {HDR0, HDR1, DATA, CHK}, except during reset.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - CHK and ERR states exist, and the trailing XOR checksum byte is consumed.
  - On mismatch, ERR is entered and o_start is never raised.
- Undefined:
  - No checksum byte is consumed; the final data word goes directly to DONE.
  - o_err is tied to 0, and the accumulator logic is not synthesized.

Test Plan:
- Feature off, BASE_ADDR=0: stream 02 00 | 13 00 10 00 | 33 85 A5 00 →
  - o_wea pulses with addr 0 / 0x00100013 and addr 1 / 0x00A58533.
  - o_words=2.
  - o_start rises one cycle after DONE and stays high.
- Stall: same stream with s_valid low for 5 cycles between bytes 2 and 3 of word 0 → identical writes, no extra o_wea, lanes preserved.
- Zero count: 00 00 → no o_wea; s_ready drops after the 2nd byte; o_start=1. reload pulse → o_start=0, s_ready=1.
- Feature on: 01 00 | 13 00 00 00 | 12 → DONE and o_start=1 (checksum 01^00^13=12). Same stream with checksum 13 → ERR, o_err=1, o_start=0.
- Assert rst after 6 data bytes of a 3-word load → all outputs return to reset values immediately. A fresh 01 00 | EF BE AD DE load writes 0xDEADBEEF at addr 0.
- BASE_ADDR=0x7FFFF, count=2 → writes at 0x7FFFF then 0x00000 (wrap).
